imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit for the decode stage. Takes an IN_W-bit instruction immediate and produces an OUT_W-bit operand in one of four modes: zero-extend, sign-extend, upper-load, and branch-offset. It also fuses an upper-load/low-OR instruction pair into a single full-width constant through an internal hold register. Input and output use valid/ready handshakes with a two-stage pipeline that sustains full throughput.

---
 rtl/imm_extend_pipe.sv | 113 +++++++++++
 tb/tb_imm_extend_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate-extension pipeline: stage A registers the raw request,
// stage B holds the extended result. Upper/low instruction pairs fuse via a hold register.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic             in_hold,
  input  logic             in_merge,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             hold_pending
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and payload stays stable while valid && !ready.

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_ZERO   = 2'd0;
  localparam logic [1:0] MODE_SIGN   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  logic             a_valid;
  logic [IN_W-1:0]  a_imm;
  logic [1:0]       a_mode;
  logic             a_hold;
  logic             a_merge;

  logic             b_valid;
  logic [OUT_W-1:0] b_data;
  logic [OUT_W-1:0] hold_reg;
  logic             hold_q;

  logic             a_is_hold;
  logic             merge_hit;
  logic             b_advance;
  logic             a_advance;
  logic [OUT_W-1:0] zext_v;
  logic [OUT_W-1:0] sext_v;
  logic [OUT_W-1:0] upper_v;
  logic [OUT_W-1:0] branch_v;
  logic [OUT_W-1:0] result;

  always_comb begin
    zext_v   = {{EXT_W{1'b0}}, a_imm};
    sext_v   = {{EXT_W{a_imm[IN_W-1]}}, a_imm};
    upper_v  = {a_imm, {EXT_W{1'b0}}};
    branch_v = {sext_v[OUT_W-3:0], 2'b00};
    case (a_mode)
      MODE_ZERO:   result = zext_v;
      MODE_SIGN:   result = sext_v;
      MODE_UPPER:  result = upper_v;
      MODE_BRANCH: result = branch_v;
      default:     result = zext_v;
    endcase
    // hold/merge flags only mean something in their own mode
    a_is_hold = a_valid && (a_mode == MODE_UPPER) && a_hold;
    merge_hit = (a_mode == MODE_ZERO) && a_merge && hold_q;
    if (merge_hit) result = hold_reg | zext_v;
  end

  // A hold entry retires into the hold register, so it never waits on stage B.
  assign b_advance = out_ready || !b_valid;
  assign a_advance = b_advance || a_is_hold;
  assign in_ready  = !a_valid || a_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_imm    <= '0;
      a_mode   <= 2'd0;
      a_hold   <= 1'b0;
      a_merge  <= 1'b0;
      b_valid  <= 1'b0;
      b_data   <= '0;
      hold_reg <= '0;
      hold_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        a_valid <= in_valid;
        if (in_valid) begin
          a_imm   <= in_imm;
          a_mode  <= in_mode;
          a_hold  <= in_hold;
          a_merge <= in_merge;
        end
      end
      if (b_advance) begin
        b_valid <= a_valid && !a_is_hold;
        if (a_valid && !a_is_hold) b_data <= result;
      end
      if (a_is_hold) begin
        hold_reg <= upper_v;
        hold_q   <= 1'b1;
      end else if (a_valid && b_advance && merge_hit) begin
        hold_reg <= '0;
        hold_q   <= 1'b0;
      end
    end
  end

  assign out_valid    = b_valid;
  assign out_data     = b_data;
  assign hold_pending = hold_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 16->32 instance plus a 12->24 instance.
module tb_imm_extend_pipe;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        in_hold;
  logic        in_merge;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        hold_pending;

  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_in_imm;
  logic [1:0]  p_in_mode;
  logic        p_in_hold;
  logic        p_in_merge;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [23:0] p_out_data;
  logic        p_hold_pending;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .in_hold(in_hold), .in_merge(in_merge),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold_pending(hold_pending)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(24)) dut_p (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm), .in_mode(p_in_mode),
    .in_hold(p_in_hold), .in_merge(p_in_merge),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .hold_pending(p_hold_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm,
                       input logic h, input logic mg);
    in_valid = v;
    in_mode  = m;
    in_imm   = imm;
    in_hold  = h;
    in_merge = mg;
  endtask

  logic [31:0] mode_exp [4];

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    out_ready  = 1'b1;
    p_in_valid = 1'b0; p_in_imm = 12'h0; p_in_mode = 2'd0;
    p_in_hold  = 1'b0; p_in_merge = 1'b0; p_out_ready = 1'b1;
    mode_exp[0] = 32'h00008001;
    mode_exp[1] = 32'hFFFF8001;
    mode_exp[2] = 32'h80010000;
    mode_exp[3] = 32'hFFFE0004;

    #3;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_hold_pending", {31'b0, hold_pending}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    tick(); tick();
    rst = 1'b0;

    // all four modes back to back, imm 8001
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 16'h8001, 1'b0, 1'b0);
      tick();
      if (i == 0) check("mode_latency_empty", {31'b0, out_valid}, 32'd0);
      else check($sformatf("mode%0d_out", i - 1), out_data, mode_exp[i-1]);
    end
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    tick();
    check("mode3_out", out_data, mode_exp[3]);
    check("mode3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("modes_drained", {31'b0, out_valid}, 32'd0);

    // hold + merge fusion on consecutive cycles
    drive(1'b1, 2'd2, 16'h1234, 1'b1, 1'b0);
    tick();
    check("fuse_pending_before", {31'b0, hold_pending}, 32'd0);
    drive(1'b1, 2'd0, 16'h5678, 1'b0, 1'b1);
    tick();
    check("fuse_pending_set", {31'b0, hold_pending}, 32'd1);
    check("fuse_hold_no_output", {31'b0, out_valid}, 32'd0);
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    tick();
    check("fuse_out", out_data, 32'h12345678);
    check("fuse_out_valid", {31'b0, out_valid}, 32'd1);
    check("fuse_pending_cleared", {31'b0, hold_pending}, 32'd0);
    tick();
    check("fuse_single_output", {31'b0, out_valid}, 32'd0);

    // merge with nothing held
    drive(1'b1, 2'd0, 16'hABCD, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    tick();
    check("plain_merge_out", out_data, 32'h0000ABCD);
    check("plain_merge_pending", {31'b0, hold_pending}, 32'd0);
    tick();

    // backpressure: 4 values, out_ready low for 5 cycles
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 16'h0011, 1'b0, 1'b0);
    #1 check("bp_ready_c0", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 2'd0, 16'h0022, 1'b0, 1'b0);
    #1 check("bp_ready_c1", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b1, 2'd0, 16'h0033, 1'b0, 1'b0);
    for (int c = 2; c < 5; c++) begin
      #1;
      check($sformatf("bp_ready_stall_c%0d", c), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp_stable_c%0d", c), out_data, 32'h00000011);
      check($sformatf("bp_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel0_ready", {31'b0, in_ready}, 32'd1);
    check("bp_rel0_out", out_data, 32'h00000011);
    tick();
    drive(1'b1, 2'd0, 16'h0044, 1'b0, 1'b0);
    #1;
    check("bp_rel1_ready", {31'b0, in_ready}, 32'd1);
    check("bp_rel1_out", out_data, 32'h00000022);
    check("bp_rel1_valid", {31'b0, out_valid}, 32'd1);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    check("bp_rel2_out", out_data, 32'h00000033);
    check("bp_rel2_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_rel3_out", out_data, 32'h00000044);
    check("bp_rel3_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // asynchronous reset with both stages full and a hold pending
    drive(1'b1, 2'd2, 16'h9999, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'd0, 16'h0002, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    #1;
    check("prerst_valid", {31'b0, out_valid}, 32'd1);
    check("prerst_pending", {31'b0, hold_pending}, 32'd1);
    check("prerst_in_ready", {31'b0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", {31'b0, out_valid}, 32'd0);
    check("rst_async_data", out_data, 32'd0);
    check("rst_async_pending", {31'b0, hold_pending}, 32'd0);
    check("rst_async_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 16'h00FF, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
    tick();
    check("postrst_merge_out", out_data, 32'h000000FF);
    check("postrst_merge_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("postrst_drained", {31'b0, out_valid}, 32'd0);

    // 12 -> 24 instance
    p_in_valid = 1'b1; p_in_mode = 2'd1; p_in_imm = 12'h800;
    tick();
    p_in_mode = 2'd2;
    tick();
    p_in_valid = 1'b0;
    check("p_sign_out", {8'h00, p_out_data}, 32'h00FFF800);
    tick();
    check("p_upper_out", {8'h00, p_out_data}, 32'h00800000);
    check("p_upper_valid", {31'b0, p_out_valid}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish before 50000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
